// File: rtl/gate_truth_table_checker.sv
// -----------------------------------------------------------------------------
// gate_truth_table_checker
//
// Exhaustively exercises an external two-input combinational gate. On start the
// block walks {a,b} through 00, 01, 10, 11. For each vector it holds the
// operands for SETTLE_CYCLES clocks, then samples o for one clock and compares
// it with the expected function selected by OP. Mismatches are recorded per
// vector in fail_vec and counted in err_count. done and pass stay valid until
// the next start or reset.
//
// Parameters:
//   OP            expected function: 0=AND, 1=OR, 2=XOR, 3=NAND
//   SETTLE_CYCLES operand hold time per vector before sampling, 1..15
//
// Optional feature (compile-time macro):
//   GATE_CHECKER_STOP_ON_FAIL_EN  when defined, the first mismatch ends the
//                                 check at once (SAMPLE -> DONE). Vectors that
//                                 were not tested keep their fail_vec bits at 0.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   request a full 4-vector check (ignored while busy)
//   a          out  operand a for the gate under test (registered)
//   b          out  operand b for the gate under test (registered)
//   o          in   result of the gate under test, combinational from a/b
//   busy       out  check in progress (SETTLE or SAMPLE)
//   done       out  results valid; held until next start or reset
//   pass       out  every checked vector matched; valid while done
//   fail_vec   out  bit {a,b} set when that vector mismatched
//   err_count  out  number of mismatches, 0..4, saturating
// -----------------------------------------------------------------------------
module gate_truth_table_checker #(
  parameter int OP            = 0,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       o,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_vec,
  output logic [2:0] err_count
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] SAMPLE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  // Last value of the settle counter before moving on to SAMPLE.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [2:0] ERR_MAX     = 3'd4;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0] state, state_next;
  logic [1:0] idx, idx_next;
  logic [3:0] settle_cnt, settle_cnt_next;
  logic       a_next, b_next;
  logic       done_next, pass_next;
  logic [3:0] fail_vec_next;
  logic [2:0] err_count_next;

  // ---------------------------------------------------------------------------
  // Reference function and comparison
  // ---------------------------------------------------------------------------
  logic expected_o;
  logic mismatch;
  logic stop_now;
  logic [3:0] fail_vec_upd;
  logic [2:0] err_count_upd;

  always_comb begin
    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    expected_o = 1'b0;
    case (OP)
      0:       expected_o = a & b;
      1:       expected_o = a | b;
      2:       expected_o = a ^ b;
      default: expected_o = ~(a & b);
    endcase
  end

  assign mismatch = (o != expected_o);

  // Result registers as they will look after the current SAMPLE edge.
  always_comb begin
    fail_vec_upd  = fail_vec;
    err_count_upd = err_count;
    if (mismatch) begin
      fail_vec_upd[idx] = 1'b1;
      if (err_count != ERR_MAX) begin
        err_count_upd = err_count + 3'd1;
      end
    end
  end

`ifdef GATE_CHECKER_STOP_ON_FAIL_EN
  assign stop_now = mismatch;
`else
  assign stop_now = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next      = state;
    idx_next        = idx;
    settle_cnt_next = settle_cnt;
    a_next          = a;
    b_next          = b;
    done_next       = done;
    pass_next       = pass;
    fail_vec_next   = fail_vec;
    err_count_next  = err_count;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next      = SETTLE;
          idx_next        = 2'd0;
          settle_cnt_next = 4'd0;
          a_next          = 1'b0;
          b_next          = 1'b0;
          done_next       = 1'b0;
          pass_next       = 1'b0;
          fail_vec_next   = 4'd0;
          err_count_next  = 3'd0;
        end
      end

      SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          state_next      = SAMPLE;
          settle_cnt_next = 4'd0;
        end else begin
          settle_cnt_next = settle_cnt + 4'd1;
        end
      end

      SAMPLE: begin
        fail_vec_next  = fail_vec_upd;
        err_count_next = err_count_upd;
        if (idx == 2'd3 || stop_now) begin
          // Operands stay on the last tested vector while in DONE.
          state_next = DONE;
          done_next  = 1'b1;
          pass_next  = (err_count_upd == 3'd0);
        end else begin
          state_next        = SETTLE;
          idx_next          = idx + 2'd1;
          {a_next, b_next}  = idx + 2'd1;
          settle_cnt_next   = 4'd0;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= 2'd0;
      settle_cnt <= 4'd0;
      a          <= 1'b0;
      b          <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_vec   <= 4'd0;
      err_count  <= 3'd0;
    end else begin
      state      <= state_next;
      idx        <= idx_next;
      settle_cnt <= settle_cnt_next;
      a          <= a_next;
      b          <= b_next;
      done       <= done_next;
      pass       <= pass_next;
      fail_vec   <= fail_vec_next;
      err_count  <= err_count_next;
    end
  end

  // busy decodes straight from the state register, so reset clears it at once.
  assign busy = (state == SETTLE) || (state == SAMPLE);

  // ---------------------------------------------------------------------------
  // Sanity properties
  // ---------------------------------------------------------------------------
  a_err_count_max : assert property (
    @(posedge clk) disable iff (!rst_n) err_count <= ERR_MAX
  );

  a_done_not_busy : assert property (
    @(posedge clk) disable iff (!rst_n) done |-> !busy
  );

  a_operands_track_idx : assert property (
    @(posedge clk) disable iff (!rst_n) busy |-> ({a, b} == idx)
  );

endmodule
